ioread_ctrl: RTL and testbench
==============================

// Module: ioread_ctrl
// PURPOSE
//  Sequences CPU I/O reads across three sources: board switches (local sync + debounce),
//  keyboard and timer peripherals (both req/ack handshake).
//  Sits between the memory/IO decoder (ior + per-device ctrl selects) and the CPU read-data mux.
//  Drives a stall to the CPU while a handshake read is outstanding.
//  Returns the selected 16-bit value in ioread_data with a one-cycle rvalid pulse.
// PARAMETERS
//  DW          16     data width of all read paths
//  DEB_CYCLES  20000  consecutive stable cycles before a switch change is accepted
//  TIMEOUT     15     cycles in REQ without ack before the read is aborted
// PORTS
//  clk          in   1   system clock, rising edge
//  reset        in   1   asynchronous, active-low reset
//  ior          in   1   CPU IO read strobe; level, held by CPU while stall=1
//  switchctrl   in   1   decoder select: switches
//  keyctrl      in   1   decoder select: keyboard
//  timerctrl    in   1   decoder select: timer
//  switch_in    in   DW  raw asynchronous switch levels
//  key_req      out  1   keyboard read request
//  key_ack      in   1   keyboard data valid
//  key_rdata    in   DW  keyboard read data
//  timer_req    out  1   timer read request
//  timer_ack    in   1   timer data valid
//  timer_rdata  in   DW  timer read data
//  ioread_data  out  DW  registered read result; holds between reads
//  rvalid       out  1   one-cycle pulse: ioread_data updated this cycle
//  stall        out  1   CPU must hold ior and wait
//  timeout_err  out  1   sticky; set on any timeout, cleared only by reset
// BEHAVIOUR
//  Reset (reset=0): state IDLE, ioread_data=0, rvalid=0, key_req=timer_req=0,
//    timeout_err=0, debounced switch value=0, all counters=0. Outputs clear immediately (async).
//  Switch path:
//    - 2-flop synchroniser, then debounce counter.
//    - Counter restarts whenever the synchronised value changes.
//    - Stable value updates once the synchronised value differs from it for DEB_CYCLES
//      consecutive cycles.
//  Select priority: switchctrl > keyctrl > timerctrl. ior with no select asserted is ignored.
//  FSM states: IDLE, REQ, DONE, DRAIN.
//  IDLE:
//    - ior & switchctrl -> DONE; data = debounced value (rvalid one cycle after ior sampled).
//    - ior & key/timer -> REQ; matching *_req asserted from the next cycle; timeout counter=0.
//  REQ:
//    - Exactly one *_req held high until ack or timeout.
//    - ack -> capture *_rdata, drop req, go DONE.
//    - TIMEOUT cycles without ack -> drop req, data=all ones, timeout_err=1, go DONE.
//    - Ack on the terminal timeout cycle: ack wins, no error.
//    - Ack on a non-selected device is ignored.
//  DONE:
//    - ioread_data loads and rvalid=1 for exactly one cycle.
//    - Next state: DRAIN if ior=1, else IDLE.
//  DRAIN: wait for ior=0, then IDLE. A held ior never retriggers a second read.
//  stall = (IDLE & ior & any select) | REQ. stall=0 in DONE and DRAIN.
//  ior dropping during REQ does not abort: the handshake completes, data latches, rvalid pulses.
//  Selects are sampled only in IDLE; changes during REQ are ignored.
// TESTING
//  1. Reset release, switch_in=16'hA5A5 stable > DEB_CYCLES, ior+switchctrl
//     -> rvalid next cycle, ioread_data=16'hA5A5, stall never high in DONE.
//  2. switch_in glitches for DEB_CYCLES-1 cycles then reverts, then read
//     -> old value returned, no change accepted.
//  3. ior+keyctrl, key_ack after 3 cycles with key_rdata=16'h0042
//     -> key_req high 3 cycles, stall high until DONE, ioread_data=16'h0042, one rvalid pulse.
//  4. ior+timerctrl, no ack
//     -> timer_req drops after TIMEOUT cycles, ioread_data=16'hFFFF, timeout_err=1 and stays 1.
//  5. ior held high 10 cycles with switchctrl+keyctrl both set
//     -> switch read only, single rvalid, no key_req, DRAIN until ior=0.
//  6. reset asserted mid-REQ
//     -> key_req and stall drop asynchronously; after release, IDLE with ioread_data=0.

Source files
------------

// File: rtl/ioread_ctrl_if.sv
// CPU/decoder/peripheral side of the IO read controller, bundled so the
// controller and its environment share one set of signal names.
interface ioread_ctrl_if #(
  parameter int DW = 16
);
  logic          ior;
  logic          switchctrl;
  logic          keyctrl;
  logic          timerctrl;
  logic [DW-1:0] switch_in;
  logic          key_req;
  logic          key_ack;
  logic [DW-1:0] key_rdata;
  logic          timer_req;
  logic          timer_ack;
  logic [DW-1:0] timer_rdata;
  logic [DW-1:0] ioread_data;
  logic          rvalid;
  logic          stall;
  logic          timeout_err;
  logic [1:0]    dbg_state;

  // Environment: CPU strobe, decoder selects, switch levels, peripheral responses.
  modport master (
    output ior, switchctrl, keyctrl, timerctrl, switch_in,
    output key_ack, key_rdata, timer_ack, timer_rdata,
    input  key_req, timer_req, ioread_data, rvalid, stall, timeout_err, dbg_state
  );

  modport slave (
    input  ior, switchctrl, keyctrl, timerctrl, switch_in,
    input  key_ack, key_rdata, timer_ack, timer_rdata,
    output key_req, timer_req, ioread_data, rvalid, stall, timeout_err, dbg_state
  );
endinterface

// File: rtl/ioread_ctrl.sv
// IO read sequencer: debounced switch reads complete directly; keyboard and
// timer reads run a req/ack handshake with timeout while the CPU is stalled.
//
// Handshake: *_req rises the cycle after the read is accepted and stays high
// until the selected *_ack is sampled high on a rising edge or the timeout
// expires. ack is only observed while req is high, and only from the selected
// device. rvalid is a one-cycle pulse marking the cycle ioread_data changed.
module ioread_ctrl #(
  parameter int DW         = 16,
  parameter int DEB_CYCLES = 20000,
  parameter int TIMEOUT    = 15
) (
  input  logic        clk,
  input  logic        reset,
  ioread_ctrl_if.slave bus
);
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam int DCW = $clog2(DEB_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DONE  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            sel_key_q, sel_key_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [DW-1:0]   data_q, data_d;
  logic            rvalid_q, rvalid_d;
  logic            err_q, err_d;

  logic [DW-1:0]   sync1_q, sync2_q, last_q;
  logic [DW-1:0]   stable_q, stable_d;
  logic [DCW-1:0]  dcnt_q, dcnt_d;
  logic [DCW-1:0]  dcnt_inc;

  logic            any_sel;
  logic            ack_sel;
  logic [DW-1:0]   rdata_sel;

  // Switch synchroniser and debounce state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      last_q   <= '0;
      stable_q <= '0;
      dcnt_q   <= '0;
    end else begin
      sync1_q  <= bus.switch_in;
      sync2_q  <= sync1_q;
      last_q   <= sync2_q;
      stable_q <= stable_d;
      dcnt_q   <= dcnt_d;
    end
  end

  // A fresh change of the synchronised value counts as the first differing cycle.
  always_comb begin
    dcnt_d   = dcnt_q;
    stable_d = stable_q;
    dcnt_inc = (sync2_q != last_q) ? DCW'(1) : dcnt_q + DCW'(1);
    if (sync2_q == stable_q) begin
      dcnt_d = '0;
    end else if (dcnt_inc >= DCW'(DEB_CYCLES)) begin
      stable_d = sync2_q;
      dcnt_d   = '0;
    end else begin
      dcnt_d = dcnt_inc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      sel_key_q <= 1'b0;
      tcnt_q    <= '0;
      data_q    <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_key_q <= sel_key_d;
      tcnt_q    <= tcnt_d;
      data_q    <= data_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
    end
  end

  assign any_sel   = bus.switchctrl | bus.keyctrl | bus.timerctrl;
  assign ack_sel   = sel_key_q ? bus.key_ack : bus.timer_ack;
  assign rdata_sel = sel_key_q ? bus.key_rdata : bus.timer_rdata;

  always_comb begin
    state_d   = state_q;
    sel_key_d = sel_key_q;
    tcnt_d    = tcnt_q;
    data_d    = data_q;
    rvalid_d  = 1'b0;
    err_d     = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.ior && bus.switchctrl) begin
          data_d   = stable_q;
          rvalid_d = 1'b1;
          state_d  = S_DONE;
        end else if (bus.ior && bus.keyctrl) begin
          sel_key_d = 1'b1;
          tcnt_d    = '0;
          state_d   = S_REQ;
        end else if (bus.ior && bus.timerctrl) begin
          sel_key_d = 1'b0;
          tcnt_d    = '0;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        // Ack is checked first so an ack on the terminal cycle still wins.
        if (ack_sel) begin
          data_d   = rdata_sel;
          rvalid_d = 1'b1;
          state_d  = S_DONE;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          data_d   = '1;
          err_d    = 1'b1;
          rvalid_d = 1'b1;
          state_d  = S_DONE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_DONE: begin
        state_d = bus.ior ? S_DRAIN : S_IDLE;
      end
      S_DRAIN: begin
        if (!bus.ior) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.key_req     = (state_q == S_REQ) &&  sel_key_q;
  assign bus.timer_req   = (state_q == S_REQ) && !sel_key_q;
  // Gated by reset so a CPU still holding ior is released during reset.
  assign bus.stall       = reset && (((state_q == S_IDLE) && bus.ior && any_sel) ||
                                     (state_q == S_REQ));
  assign bus.ioread_data = data_q;
  assign bus.rvalid      = rvalid_q;
  assign bus.timeout_err = err_q;
  assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_ioread_ctrl.sv
// Directed bench for ioread_ctrl: per-cycle vector table plus hand-written
// sequences for debounce, timeout, terminal-cycle ack and async reset.
module tb_ioread_ctrl;
  localparam int DW  = 16;
  localparam int DEB = 16;
  localparam int TO  = 15;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_DONE = 2'd2, ST_DRAIN = 2'd3;

  logic clk;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  ioread_ctrl_if #(.DW(DW)) bus ();

  ioread_ctrl #(.DW(DW), .DEB_CYCLES(DEB), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ior, sw, key, tmr, kack, tack;
    logic [15:0] krd, trd;
    logic        e_stall, e_kreq, e_treq, e_rv;
    logic [15:0] e_data;
    logic [1:0]  e_st;
  } vec_t;

  vec_t vecs[30];

  function automatic vec_t mk(input logic ior, sw, key, tmr, kack, tack,
                              input logic [15:0] krd, trd,
                              input logic e_stall, e_kreq, e_treq, e_rv,
                              input logic [15:0] e_data, input logic [1:0] e_st);
    vec_t v;
    v.ior = ior; v.sw = sw; v.key = key; v.tmr = tmr; v.kack = kack; v.tack = tack;
    v.krd = krd; v.trd = trd;
    v.e_stall = e_stall; v.e_kreq = e_kreq; v.e_treq = e_treq; v.e_rv = e_rv;
    v.e_data = e_data; v.e_st = e_st;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.ior = 1'b0; bus.switchctrl = 1'b0; bus.keyctrl = 1'b0; bus.timerctrl = 1'b0;
    bus.key_ack = 1'b0; bus.timer_ack = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_vec(input int i);
    @(posedge clk);
    #1;
    bus.ior = vecs[i].ior; bus.switchctrl = vecs[i].sw;
    bus.keyctrl = vecs[i].key; bus.timerctrl = vecs[i].tmr;
    bus.key_ack = vecs[i].kack; bus.timer_ack = vecs[i].tack;
    bus.key_rdata = vecs[i].krd; bus.timer_rdata = vecs[i].trd;
    @(negedge clk);
    chk($sformatf("v%0d_stall", i), 32'(bus.stall), 32'(vecs[i].e_stall));
    chk($sformatf("v%0d_key_req", i), 32'(bus.key_req), 32'(vecs[i].e_kreq));
    chk($sformatf("v%0d_timer_req", i), 32'(bus.timer_req), 32'(vecs[i].e_treq));
    chk($sformatf("v%0d_rvalid", i), 32'(bus.rvalid), 32'(vecs[i].e_rv));
    chk($sformatf("v%0d_data", i), 32'(bus.ioread_data), 32'(vecs[i].e_data));
    chk($sformatf("v%0d_state", i), 32'(bus.dbg_state), 32'(vecs[i].e_st));
  endtask

  initial begin
    int  treq_cnt;
    bit  got_rv;

    // Part A: switch read, key read with foreign ack, timer read with ior drop
    vecs[0]  = mk(1,1,0,0,0,0, 16'h0000,16'h0000, 1,0,0,0, 16'h0000, ST_IDLE);
    vecs[1]  = mk(0,0,0,0,0,0, 16'h0000,16'h0000, 0,0,0,1, 16'hA5A5, ST_DONE);
    vecs[2]  = mk(0,0,0,0,0,0, 16'h0000,16'h0000, 0,0,0,0, 16'hA5A5, ST_IDLE);
    vecs[3]  = mk(1,0,1,0,0,0, 16'h0042,16'h0000, 1,0,0,0, 16'hA5A5, ST_IDLE);
    vecs[4]  = mk(1,0,1,0,0,0, 16'h0042,16'h0000, 1,1,0,0, 16'hA5A5, ST_REQ);
    vecs[5]  = mk(1,0,1,0,0,1, 16'h0042,16'h0000, 1,1,0,0, 16'hA5A5, ST_REQ);
    vecs[6]  = mk(1,0,1,0,1,0, 16'h0042,16'h0000, 1,1,0,0, 16'hA5A5, ST_REQ);
    vecs[7]  = mk(0,0,0,0,0,0, 16'h0042,16'h0000, 0,0,0,1, 16'h0042, ST_DONE);
    vecs[8]  = mk(0,0,0,0,0,0, 16'h0042,16'h0000, 0,0,0,0, 16'h0042, ST_IDLE);
    vecs[9]  = mk(1,0,0,1,0,0, 16'h0000,16'h1234, 1,0,0,0, 16'h0042, ST_IDLE);
    vecs[10] = mk(0,0,1,0,0,0, 16'h0000,16'h1234, 1,0,1,0, 16'h0042, ST_REQ);
    vecs[11] = mk(0,0,0,0,1,0, 16'h0000,16'h1234, 1,0,1,0, 16'h0042, ST_REQ);
    vecs[12] = mk(0,0,0,0,0,1, 16'h0000,16'h1234, 1,0,1,0, 16'h0042, ST_REQ);
    vecs[13] = mk(0,0,0,0,0,0, 16'h0000,16'h1234, 0,0,0,1, 16'h1234, ST_DONE);
    vecs[14] = mk(0,0,0,0,0,0, 16'h0000,16'h1234, 0,0,0,0, 16'h1234, ST_IDLE);
    // Part B: held ior with switch+key selects, drain, then ior without select
    vecs[15] = mk(1,1,1,0,0,0, 16'h0000,16'h0000, 1,0,0,0, 16'hFFFF, ST_IDLE);
    vecs[16] = mk(1,1,1,0,0,0, 16'h0000,16'h0000, 0,0,0,1, 16'h5A5A, ST_DONE);
    for (int i = 17; i <= 24; i++)
      vecs[i] = mk(1,1,1,0,0,0, 16'h0000,16'h0000, 0,0,0,0, 16'h5A5A, ST_DRAIN);
    vecs[25] = mk(0,0,0,0,0,0, 16'h0000,16'h0000, 0,0,0,0, 16'h5A5A, ST_DRAIN);
    vecs[26] = mk(0,0,0,0,0,0, 16'h0000,16'h0000, 0,0,0,0, 16'h5A5A, ST_IDLE);
    vecs[27] = mk(1,0,0,0,0,0, 16'h0000,16'h0000, 0,0,0,0, 16'h5A5A, ST_IDLE);
    vecs[28] = mk(1,0,0,0,0,0, 16'h0000,16'h0000, 0,0,0,0, 16'h5A5A, ST_IDLE);
    vecs[29] = mk(0,0,0,0,0,0, 16'h0000,16'h0000, 0,0,0,0, 16'h5A5A, ST_IDLE);

    reset = 1'b0;
    idle_inputs();
    bus.switch_in = 16'hA5A5;
    bus.key_rdata = '0;
    bus.timer_rdata = '0;
    cycles(3);
    bus.ior = 1'b1; bus.switchctrl = 1'b1;
    @(negedge clk);
    chk("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    chk("rst_data", 32'(bus.ioread_data), 32'h0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'h0);
    chk("rst_reqs", 32'({bus.key_req, bus.timer_req}), 32'h0);
    chk("rst_stall", 32'(bus.stall), 32'h0);
    chk("rst_err", 32'(bus.timeout_err), 32'h0);
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    cycles(25);

    // Glitch one cycle short of the debounce window: must be rejected
    bus.switch_in = 16'h5A5A;
    cycles(DEB - 1);
    bus.switch_in = 16'hA5A5;
    cycles(25);

    for (int i = 0; i <= 14; i++) apply_vec(i);
    chk("a_err", 32'(bus.timeout_err), 32'h0);

    // Key ack arriving on the terminal timeout cycle
    @(posedge clk); #1;
    bus.ior = 1'b1; bus.keyctrl = 1'b1; bus.key_rdata = 16'hBEEF;
    for (int i = 1; i <= TO; i++) begin
      @(posedge clk); #1;
      bus.keyctrl = 1'b0;
      bus.key_ack = (i == TO);
      @(negedge clk);
      chk($sformatf("term_kreq%0d", i), 32'(bus.key_req), 32'h1);
    end
    @(posedge clk); #1;
    bus.key_ack = 1'b0; bus.ior = 1'b0;
    @(negedge clk);
    chk("term_rvalid", 32'(bus.rvalid), 32'h1);
    chk("term_data", 32'(bus.ioread_data), 32'hBEEF);
    chk("term_err", 32'(bus.timeout_err), 32'h0);
    chk("term_kreq_drop", 32'(bus.key_req), 32'h0);
    cycles(2);

    // Timer read with no ack: timeout
    bus.ior = 1'b1; bus.timerctrl = 1'b1;
    @(negedge clk);
    chk("to_stall_idle", 32'(bus.stall), 32'h1);
    treq_cnt = 0;
    got_rv = 1'b0;
    for (int c = 0; c < 40 && !got_rv; c++) begin
      @(posedge clk); #1;
      bus.timerctrl = 1'b0;
      @(negedge clk);
      if (bus.timer_req) treq_cnt++;
      if (bus.rvalid) begin
        got_rv = 1'b1;
        chk("to_data", 32'(bus.ioread_data), 32'hFFFF);
        chk("to_err", 32'(bus.timeout_err), 32'h1);
        chk("to_stall_done", 32'(bus.stall), 32'h0);
      end
    end
    chk("to_rvalid_seen", 32'(got_rv), 32'h1);
    chk("to_treq_cycles", 32'(treq_cnt), 32'(TO));
    @(posedge clk); #1;
    @(negedge clk);
    chk("to_drain", 32'(bus.dbg_state), 32'(ST_DRAIN));
    bus.ior = 1'b0;
    bus.switch_in = 16'h5A5A;
    cycles(25);
    chk("to_err_sticky", 32'(bus.timeout_err), 32'h1);

    for (int i = 15; i <= 29; i++) apply_vec(i);
    chk("b_err_sticky", 32'(bus.timeout_err), 32'h1);

    // Asynchronous reset in the middle of a key handshake
    @(posedge clk); #1;
    bus.ior = 1'b1; bus.keyctrl = 1'b1;
    @(posedge clk); #1;
    bus.keyctrl = 1'b0;
    #1;
    chk("ar_kreq_before", 32'(bus.key_req), 32'h1);
    chk("ar_stall_before", 32'(bus.stall), 32'h1);
    reset = 1'b0;
    #1;
    chk("ar_kreq", 32'(bus.key_req), 32'h0);
    chk("ar_stall", 32'(bus.stall), 32'h0);
    chk("ar_err", 32'(bus.timeout_err), 32'h0);
    chk("ar_data", 32'(bus.ioread_data), 32'h0);
    bus.ior = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("ar_state_post", 32'(bus.dbg_state), 32'(ST_IDLE));
    chk("ar_data_post", 32'(bus.ioread_data), 32'h0);
    chk("ar_rvalid_post", 32'(bus.rvalid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
